// File: rtl/conv2d_stream.sv
// Streaming 3x3 valid-mode convolution over an IMG_W x IMG_H raster frame.
// Two line buffers feed a sliding window; a two-stage pipeline forms products, then a shifted, saturated sum.
module conv2d_stream #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ACC_W  = 20,
    parameter int SHIFT  = 4,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              in_st,
    input  logic              coef_we,
    input  logic [3:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_din,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_din,
    output logic [OUT_W-1:0]  dout,
    output logic              out_st,
    input  logic              out_ready,
    output logic              frame_done
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int K_DEF [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

    typedef enum logic {
        RUN,
        FLUSH
    } state_e;

    state_e              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COEF_W-1:0]   coef_q [9];
    logic [COEF_W-1:0]   coef_d [9];
    logic [DATA_W-1:0]   win_q [3][3];
    logic [DATA_W-1:0]   win_d [3][3];
    logic [PROD_W-1:0]   prod_q [9];
    logic [PROD_W-1:0]   prod_d [9];
    logic [DATA_W-1:0]   lb_top_mem [IMG_W];
    logic [DATA_W-1:0]   lb_mid_mem [IMG_W];
    logic                s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0]    dout_q, dout_d;
    logic                out_st_q, out_st_d;
    logic                frame_done_q, frame_done_d;
    logic                ready_en_q;

    logic                stall;
    logic                accept;
    logic                last_col;
    logic                last_row;
    logic                win_done;
    logic                final_consume;
    logic [ACC_W-1:0]    sum;
    logic [ACC_W-1:0]    shifted;
    logic [OUT_W-1:0]    sat_val;

    // NOTE: every signal written in an always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        stall         = out_st_q && !out_ready;
        pix_ready     = ready_en_q && (state_q == RUN) && !stall;
        accept        = pix_valid && pix_ready;
        last_col      = (col_q == COL_W'(IMG_W - 1));
        last_row      = (row_q == ROW_W'(IMG_H - 1));
        win_done      = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
        // With nothing left in stage 1, the result in dout is the last one of the frame.
        final_consume = (state_q == FLUSH) && out_st_q && out_ready && !s1_valid_q;
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (accept) begin
            col_d = last_col ? '0 : col_q + COL_W'(1);
            if (last_col) begin
                row_d = last_row ? '0 : row_q + ROW_W'(1);
            end
            if (last_col && last_row) begin
                state_d = FLUSH;
            end
        end
        if (final_consume) begin
            state_d = RUN;
            col_d   = '0;
            row_d   = '0;
        end
    end

    always_comb begin
        coef_d = coef_q;
        for (int i = 0; i < 9; i++) begin
            if (coef_we && (coef_addr == 4'(i))) begin
                coef_d[i] = coef_din;
            end
        end
    end

    // Shift the window left and bring in the new column: two buffered rows above the live pixel.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb_top_mem[col_q];
            win_d[1][2] = lb_mid_mem[col_q];
            win_d[2][2] = pix_din;
        end
    end

    always_comb begin
        prod_d     = prod_q;
        s1_valid_d = s1_valid_q;
        if (!stall) begin
            s1_valid_d = win_done;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    prod_d[r*3 + c] = PROD_W'(win_d[r][c]) * PROD_W'(coef_q[r*3 + c]);
                end
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < 9; i++) begin
            sum = sum + ACC_W'(prod_q[i]);
        end
        shifted = sum >> SHIFT;
        sat_val = ((shifted >> OUT_W) != '0) ? '1 : OUT_W'(shifted);

        out_st_d     = out_st_q;
        dout_d       = dout_q;
        frame_done_d = final_consume;
        if (!stall) begin
            out_st_d = s1_valid_q;
            if (s1_valid_q) begin
                dout_d = sat_val;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (in_st) begin
            state_q      <= RUN;
            col_q        <= '0;
            row_q        <= '0;
            s1_valid_q   <= 1'b0;
            out_st_q     <= 1'b0;
            dout_q       <= '0;
            frame_done_q <= 1'b0;
            ready_en_q   <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                coef_q[i] <= COEF_W'(K_DEF[i]);
            end
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            s1_valid_q   <= s1_valid_d;
            out_st_q     <= out_st_d;
            dout_q       <= dout_d;
            frame_done_q <= frame_done_d;
            ready_en_q   <= 1'b1;
            coef_q       <= coef_d;
        end
    end

    // NOTE: line buffers, window and products carry no reset; they are only read under valid flags that do.
    always_ff @(posedge clk) begin
        win_q  <= win_d;
        prod_q <= prod_d;
        if (accept) begin
            lb_top_mem[col_q] <= lb_mid_mem[col_q];
            lb_mid_mem[col_q] <= pix_din;
        end
    end

    assign dout       = dout_q;
    assign out_st     = out_st_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv2d_stream.sv
// Directed bench for conv2d_stream: flat, ramp, saturation, backpressure, mid-frame reset and kernel reload.
// A second instance with SHIFT=0 shares all inputs so the saturation case can be observed.
module tb_conv2d_stream;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NRES = (W - 2) * (H - 2);

    logic        clk = 1'b0;
    logic        in_st;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [7:0]  coef_din;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_din;
    logic [15:0] dout;
    logic        out_st;
    logic        out_ready;
    logic        frame_done;

    logic        pix_ready_s;
    logic [15:0] dout_s;
    logic        out_st_s;
    logic        frame_done_s;

    always #5 clk = ~clk;

    conv2d_stream dut (
        .clk        (clk),
        .in_st      (in_st),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_din   (coef_din),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_din    (pix_din),
        .dout       (dout),
        .out_st     (out_st),
        .out_ready  (out_ready),
        .frame_done (frame_done)
    );

    conv2d_stream #(.SHIFT(0)) dut_s (
        .clk        (clk),
        .in_st      (in_st),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_din   (coef_din),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready_s),
        .pix_din    (pix_din),
        .dout       (dout_s),
        .out_st     (out_st_s),
        .out_ready  (out_ready),
        .frame_done (frame_done_s)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    logic [7:0]  frame_px [W*H];
    logic [15:0] got_q [$];
    logic [15:0] got_s_q [$];
    int          exp_q [$];

    int n_cons;
    int n_acc;
    int fd_cnt;
    int fd_cyc;
    int last_cons_cyc;
    int first_out_cyc;
    int acc19_cyc;
    int stall_after;
    bit stall_armed = 1'b0;
    int stall_left  = 0;
    int stall_hits;
    bit held        = 1'b0;
    logic [15:0] held_dout;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: owns out_ready, records consumed results and checks stall behaviour.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (stall_armed && n_cons == stall_after) begin
                stall_left  = 5;
                stall_armed = 1'b0;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            #1;
            if (out_st === 1'b1 && out_ready) begin
                got_q.push_back(dout);
                got_s_q.push_back(dout_s);
                n_cons++;
                last_cons_cyc = cyc;
            end
            if (out_st === 1'b1 && first_out_cyc < 0) first_out_cyc = cyc;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            if (out_st === 1'b1 && !out_ready) begin
                stall_hits++;
                check("stall_pix_ready", pix_ready, 0);
                if (held) check("stall_dout_stable", dout, held_dout);
                else begin
                    held      = 1'b1;
                    held_dout = dout;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic start_test();
        got_q.delete();
        got_s_q.delete();
        exp_q.delete();
        n_cons        = 0;
        n_acc         = 0;
        fd_cnt        = 0;
        fd_cyc        = -1;
        last_cons_cyc = -1;
        first_out_cyc = -1;
        acc19_cyc     = -1;
        stall_hits    = 0;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < W*H; i++) frame_px[i] = 8'(i);
    endtask

    task automatic push_centre();
        for (int r = 0; r < H-2; r++)
            for (int c = 0; c < W-2; c++)
                exp_q.push_back(int'(frame_px[(r+1)*W + c + 1]));
    endtask

    task automatic send_pix(input logic [7:0] v);
        int waited = 0;
        bit done   = 1'b0;
        pix_valid = 1'b1;
        pix_din   = v;
        while (!done && waited < 200) begin
            @(negedge clk);
            #1;
            if (pix_ready === 1'b1) begin
                n_acc++;
                if (n_acc == (2*W + 3)) acc19_cyc = cyc;
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                waited++;
            end
        end
        if (!done) check("pix_accept_timeout", 32'(done), 1);
    endtask

    task automatic send_pixels(input int n);
        for (int i = 0; i < n; i++) send_pix(frame_px[i]);
        pix_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (fd_cnt < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check("frame_done_count", fd_cnt, target);
    endtask

    task automatic check_results(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s[%0d]", tag, i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, exp_q[i]);
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [7:0] v);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_din  = v;
        @(posedge clk);
        #1;
        coef_we   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_miss);
        $fatal(1);
    end

    initial begin
        in_st = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_din = '0;
        pix_valid = 1'b0; pix_din = '0;
        start_test();
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", dout, 0);
        check("rst_out_st", out_st, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_pix_ready", pix_ready, 0);
        in_st = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_pix_ready", pix_ready, 1);

        // Flat frame of 16s: weights sum to 16, so every result is 16.
        start_test();
        for (int i = 0; i < W*H; i++) frame_px[i] = 8'd16;
        push_centre();
        send_pixels(W*H);
        wait_frames(1);
        check_results("flat16");
        check("first_out_latency", first_out_cyc - acc19_cyc, 2);
        check("frame_done_latency", fd_cyc - last_cons_cyc, 1);

        // Ramp: a linear image through the 1-2-1 kernel returns the centre pixel.
        start_test();
        load_ramp();
        push_centre();
        send_pixels(W*H);
        wait_frames(1);
        check_results("ramp");
        check("ramp_first", got_q.size() > 0 ? 32'(got_q[0]) : 32'hDEAD, 9);
        check("ramp_last", got_q.size() == NRES ? 32'(got_q[NRES-1]) : 32'hDEAD, 54);

        // Backpressure: out_ready low for 5 cycles after the 10th result.
        start_test();
        load_ramp();
        push_centre();
        stall_after = 10;
        stall_armed = 1'b1;
        send_pixels(W*H);
        wait_frames(1);
        check_results("stall_ramp");
        check("stall_seen", 32'(stall_hits >= 3), 1);

        // Mid-frame reset with a modified kernel, then a fresh ramp frame.
        write_coef(4'd0, 8'd7);
        start_test();
        load_ramp();
        send_pixels(30);
        in_st = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_dout", dout, 0);
        check("midrst_out_st", out_st, 0);
        check("midrst_pix_ready", pix_ready, 0);
        in_st = 1'b0;
        start_test();
        repeat (6) begin
            @(posedge clk);
            #1;
            check("post_reset_quiet", out_st, 0);
        end
        push_centre();
        send_pixels(W*H);
        wait_frames(1);
        check_results("after_reset");

        // All-255 kernel and pixels: 9*255*255 = 585225 saturates at SHIFT=0, 36576 at SHIFT=4.
        for (int i = 0; i < 9; i++) write_coef(4'(i), 8'd255);
        write_coef(4'd15, 8'd0);
        start_test();
        for (int i = 0; i < W*H; i++) frame_px[i] = 8'd255;
        for (int i = 0; i < NRES; i++) exp_q.push_back(65535);
        send_pixels(W*H);
        wait_frames(1);
        check("sat_count", got_s_q.size(), NRES);
        for (int i = 0; i < got_s_q.size(); i++) check($sformatf("sat[%0d]", i), got_s_q[i], 65535);
        for (int i = 0; i < got_q.size(); i++) check($sformatf("nosat[%0d]", i), got_q[i], 36576);

        // Centre-only kernel across two back-to-back frames; out-of-range writes ignored.
        for (int i = 0; i < 9; i++) write_coef(4'(i), (i == 4) ? 8'd16 : 8'd0);
        write_coef(4'd12, 8'd99);
        write_coef(4'd9, 8'd50);
        start_test();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) frame_px[r*W + c] = 8'((r*37 + c*11 + 5) % 256);
        push_centre();
        send_pixels(W*H);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) frame_px[r*W + c] = 8'(255 - (r*19 + c*23) % 200);
        push_centre();
        send_pixels(W*H);
        wait_frames(2);
        check_results("centre_b2b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
